// File: rtl/rv32i_types.sv
// Shared line/burst types for the cache memory side and the burst adaptor state encoding.
package rv32i_types;

    localparam int s_offset  = 5;
    localparam int s_burst   = 64;
    localparam int s_line    = 8 * (2 ** s_offset);
    localparam int num_beats = s_line / s_burst;
    localparam int beat_w    = $clog2(num_beats);

    typedef logic [s_line-1:0]               llc_cacheline;
    typedef logic [s_burst-1:0]              burst_word;
    typedef logic [beat_w-1:0]               beat_idx_t;
    typedef burst_word [num_beats-1:0]       line_beats_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } cba_state_t;

    localparam beat_idx_t   last_beat = beat_idx_t'(num_beats - 1);
    localparam logic [31:0] line_mask = ~32'(2 ** s_offset - 1);

    // Beat k of a line occupies bits [k*s_burst +: s_burst].
    function automatic burst_word get_beat(input llc_cacheline line, input beat_idx_t idx);
        line_beats_t beats;
        beats = line_beats_t'(line);
        return beats[idx];
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Serialises one cache line request into a fixed-length burst toward memory and
// reassembles read beats back into a line, pulsing line_resp_o once per line.
module cacheline_burst_adaptor
    import rv32i_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                line_read_i,
    input  logic                line_write_i,
    input  logic [31:0]         line_address_i,
    input  llc_cacheline        line_wdata_i,
    output llc_cacheline        line_rdata_o,
    output logic                line_resp_o,
    output logic [31:0]         burst_address_o,
    output logic                burst_read_o,
    output logic                burst_write_o,
    output burst_word           burst_wdata_o,
    input  burst_word           burst_rdata_i,
    input  logic                burst_resp_i
);

    // state    | meaning
    // IDLE     | sampling line_read_i / line_write_i (read wins)
    // RD_BURST | burst_read_o high, capturing one beat per burst_resp_i
    // WR_BURST | burst_write_o high, presenting buffered beat k
    // DONE     | line_resp_o pulse, counter cleared, requests ignored

    cba_state_t   state;
    beat_idx_t    beat_cnt;
    beat_idx_t    beat_next;
    llc_cacheline wdata_buf;
    line_beats_t  rdata_beats;

    assign beat_next    = beat_cnt + 1'b1;
    assign line_rdata_o = llc_cacheline'(rdata_beats);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            beat_cnt        <= '0;
            wdata_buf       <= '0;
            rdata_beats     <= '0;
            line_resp_o     <= 1'b0;
            burst_address_o <= '0;
            burst_read_o    <= 1'b0;
            burst_write_o   <= 1'b0;
            burst_wdata_o   <= '0;
        end else begin
            line_resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_read_i) begin
                        state           <= RD_BURST;
                        burst_read_o    <= 1'b1;
                        burst_address_o <= line_address_i & line_mask;
                    end else if (line_write_i) begin
                        state           <= WR_BURST;
                        burst_write_o   <= 1'b1;
                        burst_address_o <= line_address_i & line_mask;
                        wdata_buf       <= line_wdata_i;
                        burst_wdata_o   <= get_beat(line_wdata_i, '0);
                    end
                end
                RD_BURST: begin
                    if (burst_resp_i) begin
                        rdata_beats[beat_cnt] <= burst_rdata_i;
                        beat_cnt              <= beat_next;
                        if (beat_cnt == last_beat) begin
                            state           <= DONE;
                            burst_read_o    <= 1'b0;
                            burst_address_o <= '0;
                            line_resp_o     <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (burst_resp_i) begin
                        beat_cnt      <= beat_next;
                        burst_wdata_o <= get_beat(wdata_buf, beat_next);
                        if (beat_cnt == last_beat) begin
                            state           <= DONE;
                            burst_write_o   <= 1'b0;
                            burst_address_o <= '0;
                            line_resp_o     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: reads, writes with stalls, reset abort and back-to-back lines.
module tb_cacheline_burst_adaptor;

    logic         clk;
    logic         rst;
    logic         line_read_i;
    logic         line_write_i;
    logic [31:0]  line_address_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  burst_address_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic [63:0]  burst_wdata_o;
    logic [63:0]  burst_rdata_i;
    logic         burst_resp_i;

    int checks;
    int errors;

    cacheline_burst_adaptor dut (
        .clk             (clk),
        .rst             (rst),
        .line_read_i     (line_read_i),
        .line_write_i    (line_write_i),
        .line_address_i  (line_address_i),
        .line_wdata_i    (line_wdata_i),
        .line_rdata_o    (line_rdata_o),
        .line_resp_o     (line_resp_o),
        .burst_address_o (burst_address_o),
        .burst_read_o    (burst_read_o),
        .burst_write_o   (burst_write_o),
        .burst_wdata_o   (burst_wdata_o),
        .burst_rdata_i   (burst_rdata_i),
        .burst_resp_i    (burst_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side of a read: called on the first negedge where burst_read_o should be high.
    // Returns on the negedge of the line_resp_o cycle.
    task automatic serve_read(input logic [63:0] beats [4], input int waits, input logic [31:0] exp_addr);
        logic [255:0] exp_line;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w <= waits; w++) begin
                burst_resp_i  = (w == waits);
                burst_rdata_i = (w == waits) ? beats[k] : 64'hDEAD_BEEF_DEAD_BEEF;
                checks++;
                if (burst_read_o !== 1'b1 || burst_write_o !== 1'b0 || line_resp_o !== 1'b0 ||
                    burst_address_o !== exp_addr) begin
                    errors++;
                    $display("FAIL rd_beat%0d: rd=%b wr=%b resp=%b addr=%h required rd=1 wr=0 resp=0 addr=%h",
                             k, burst_read_o, burst_write_o, line_resp_o, burst_address_o, exp_addr);
                end
                @(negedge clk);
            end
        end
        burst_resp_i  = 1'b0;
        burst_rdata_i = '0;
        checks++;
        if (line_resp_o !== 1'b1 || burst_read_o !== 1'b0 || burst_address_o !== 32'h0) begin
            errors++;
            $display("FAIL rd_done: resp=%b rd=%b addr=%h required resp=1 rd=0 addr=0",
                     line_resp_o, burst_read_o, burst_address_o);
        end
        checks++;
        if (line_rdata_o !== exp_line) begin
            errors++;
            $display("FAIL rd_line: got %h required %h", line_rdata_o, exp_line);
        end
    endtask

    task automatic serve_write(input logic [63:0] slices [4], input int waits, input logic [31:0] exp_addr);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w <= waits; w++) begin
                burst_resp_i = (w == waits);
                checks++;
                if (burst_write_o !== 1'b1 || burst_read_o !== 1'b0 || line_resp_o !== 1'b0 ||
                    burst_address_o !== exp_addr || burst_wdata_o !== slices[k]) begin
                    errors++;
                    $display("FAIL wr_beat%0d: wr=%b rd=%b resp=%b addr=%h wdata=%h required wr=1 rd=0 resp=0 addr=%h wdata=%h",
                             k, burst_write_o, burst_read_o, line_resp_o, burst_address_o, burst_wdata_o,
                             exp_addr, slices[k]);
                end
                @(negedge clk);
            end
        end
        burst_resp_i = 1'b0;
        checks++;
        if (line_resp_o !== 1'b1 || burst_write_o !== 1'b0 || burst_address_o !== 32'h0) begin
            errors++;
            $display("FAIL wr_done: resp=%b wr=%b addr=%h required resp=1 wr=0 addr=0",
                     line_resp_o, burst_write_o, burst_address_o);
        end
    endtask

    task automatic check_resp_gone(input string tag);
        @(negedge clk);
        checks++;
        if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || burst_write_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: resp=%b rd=%b wr=%b required all 0", tag, line_resp_o, burst_read_o, burst_write_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || burst_write_o !== 1'b0 ||
            burst_address_o !== 32'h0 || burst_wdata_o !== 64'h0 || line_rdata_o !== 256'h0) begin
            errors++;
            $display("FAIL reset: resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h required all 0",
                     line_resp_o, burst_read_o, burst_write_o, burst_address_o, burst_wdata_o, line_rdata_o);
        end
    endtask

    task automatic test_read_no_wait();
        logic [63:0] beats [4];
        beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        line_read_i    = 1'b1;
        line_address_i = 32'h0000_1234;
        @(negedge clk);
        serve_read(beats, 0, 32'h0000_1220);
        line_read_i = 1'b0;
        check_resp_gone("read_no_wait");
    endtask

    task automatic test_write_waits();
        logic [63:0] slices [4];
        slices = '{64'h0123_4567_89AB_CDEF, 64'h89AB_CDEF_0123_4567,
                   64'hFEDC_BA98_7654_3210, 64'h7654_3210_FEDC_BA98};
        line_write_i   = 1'b1;
        line_address_i = 32'hABCD_EF7F;
        line_wdata_i   = {slices[3], slices[2], slices[1], slices[0]};
        @(negedge clk);
        serve_write(slices, 2, 32'hABCD_EF60);
        line_write_i = 1'b0;
        check_resp_gone("write_waits");
    endtask

    task automatic test_data_stability();
        logic [63:0] slices [4];
        slices = '{64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002,
                   64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0004};
        line_write_i   = 1'b1;
        line_address_i = 32'h0000_0040;
        line_wdata_i   = {slices[3], slices[2], slices[1], slices[0]};
        @(negedge clk);
        line_wdata_i = '1;
        serve_write(slices, 1, 32'h0000_0040);
        line_write_i = 1'b0;
        check_resp_gone("stability");
    endtask

    task automatic test_simultaneous();
        logic [63:0] beats [4];
        beats = '{64'h0000_0000_0000_00A0, 64'h0000_0000_0000_00B1,
                  64'h0000_0000_0000_00C2, 64'h0000_0000_0000_00D3};
        line_read_i    = 1'b1;
        line_write_i   = 1'b1;
        line_wdata_i   = '1;
        line_address_i = 32'h1000_0008;
        @(negedge clk);
        serve_read(beats, 0, 32'h1000_0000);
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        check_resp_gone("simultaneous");
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] beats [4];
        beats = '{64'h5555_0000_0000_5555, 64'h6666_0000_0000_6666,
                  64'h7777_0000_0000_7777, 64'h8888_0000_0000_8888};
        line_read_i    = 1'b1;
        line_address_i = 32'h0000_2000;
        @(negedge clk);
        burst_resp_i  = 1'b1;
        burst_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        burst_rdata_i = 64'hBAD1_BAD1_BAD1_BAD1;
        @(negedge clk);
        burst_resp_i  = 1'b0;
        burst_rdata_i = '0;
        line_read_i   = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || burst_write_o !== 1'b0 ||
            burst_address_o !== 32'h0 || burst_wdata_o !== 64'h0 || line_rdata_o !== 256'h0) begin
            errors++;
            $display("FAIL reset_mid_read: resp=%b rd=%b wr=%b addr=%h rdata=%h required all 0",
                     line_resp_o, burst_read_o, burst_write_o, burst_address_o, line_rdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        line_read_i    = 1'b1;
        line_address_i = 32'h8000_003F;
        @(negedge clk);
        serve_read(beats, 0, 32'h8000_0020);
        line_read_i = 1'b0;
        check_resp_gone("read_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [63:0] beats [4];
        logic [63:0] slices [4];
        beats  = '{64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
                   64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3};
        slices = '{64'hB0B0_0000_0000_0000, 64'hB1B1_0000_0000_0000,
                   64'hB2B2_0000_0000_0000, 64'hB3B3_0000_0000_0000};
        line_read_i    = 1'b1;
        line_address_i = 32'h0000_3000;
        @(negedge clk);
        serve_read(beats, 1, 32'h0000_3000);
        line_read_i    = 1'b0;
        line_write_i   = 1'b1;
        line_address_i = 32'h0000_4010;
        line_wdata_i   = {slices[3], slices[2], slices[1], slices[0]};
        @(negedge clk);
        checks++;
        if (burst_write_o !== 1'b0 || line_resp_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: wr=%b resp=%b required wr=0 resp=0", burst_write_o, line_resp_o);
        end
        @(negedge clk);
        serve_write(slices, 0, 32'h0000_4000);
        line_write_i = 1'b0;
        checks++;
        if (line_rdata_o !== {beats[3], beats[2], beats[1], beats[0]}) begin
            errors++;
            $display("FAIL b2b_rdata_hold: got %h required %h", line_rdata_o, {beats[3], beats[2], beats[1], beats[0]});
        end
        check_resp_gone("back_to_back");
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        line_read_i    = 1'b0;
        line_write_i   = 1'b0;
        line_address_i = '0;
        line_wdata_i   = '0;
        burst_rdata_i  = '0;
        burst_resp_i   = 1'b0;
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_read_no_wait();
        test_write_waits();
        test_data_stability();
        test_simultaneous();
        test_reset_mid_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
